// File: rtl/dct8_1d_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dct8_1d_engine : serial-MAC 8-point orthonormal DCT-II with a start2/done2 |
// | handshake. Optional macro DCT_IDCT_EN adds port inv (transposed table).    |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module dct8_1d_engine #(
   parameter int DW = 16,
   parameter int CW = 12,
   parameter int OW = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start2,
`ifdef DCT_IDCT_EN
   input  logic            inv,
`endif
   input  logic [8*DW-1:0] x_in,
   output logic            done2,
   output logic            busy,
   output logic [8*OW-1:0] y_out
);

   localparam int AW = DW + CW + 3;
   localparam logic signed [AW-1:0] c_SAT_HI = AW'((64'sd1 <<< (OW-1)) - 64'sd1);
   localparam logic signed [AW-1:0] c_SAT_LO = ~c_SAT_HI;
   localparam logic signed [AW-1:0] c_RND    = AW'(64'sd1 <<< (CW-2));

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Table entries are held as Q1.11 cosine magnitudes folded into the first
   // quadrant, then rescaled to Q1.(CW-1).
   function automatic logic signed [CW-1:0] f_coef(input logic [2:0] k, input logic [2:0] n);
      logic [4:0]             a;
      logic                   neg;
      logic signed [12:0]     base;
      logic signed [CW+12:0]  scaled;
      a   = {1'b0, n, 1'b1} * {2'b00, k};
      neg = 1'b0;
      if (a > 5'd16) a = 5'd0 - a;
      if (a > 5'd8) begin
         a   = 5'd16 - a;
         neg = 1'b1;
      end
      case (a)
         5'd0:    base = 13'sd1024;
         5'd1:    base = 13'sd1004;
         5'd2:    base = 13'sd946;
         5'd3:    base = 13'sd851;
         5'd4:    base = 13'sd724;
         5'd5:    base = 13'sd569;
         5'd6:    base = 13'sd392;
         5'd7:    base = 13'sd200;
         default: base = 13'sd0;
      endcase
      if (k == 3'd0) base = 13'sd724;
      if (neg) base = -base;
      scaled = (CW+13)'(base) <<< CW;
      return CW'(scaled >>> 12);
   endfunction

   state_t                r_state;
   logic signed [DW-1:0]  r_x [8];
   logic signed [OW-1:0]  r_y [8];
   logic signed [AW-1:0]  r_acc;
   logic [2:0]            r_k;
   logic [2:0]            r_n;
`ifdef DCT_IDCT_EN
   logic                  r_inv;
`endif

   logic signed [DW-1:0]  w_x;
   logic signed [CW-1:0]  w_c;
   logic signed [AW-1:0]  w_prod;
   logic signed [AW-1:0]  w_sum;
   logic signed [AW-1:0]  w_rnd;
   logic signed [AW-1:0]  w_shr;
   logic signed [OW-1:0]  w_sat;
   logic [8*OW-1:0]       w_y_next;

   assign w_x = r_x[r_n];
`ifdef DCT_IDCT_EN
   assign w_c = r_inv ? f_coef(r_n, r_k) : f_coef(r_k, r_n);
`else
   assign w_c = f_coef(r_k, r_n);
`endif
   assign w_prod = AW'(w_x) * AW'(w_c);
   assign w_sum  = r_acc + w_prod;
   assign w_rnd  = w_sum + c_RND;
   assign w_shr  = w_rnd >>> (CW-1);

   always_comb begin
      w_sat = OW'(w_shr);
      if (w_shr > c_SAT_HI)      w_sat = OW'(c_SAT_HI);
      else if (w_shr < c_SAT_LO) w_sat = OW'(c_SAT_LO);
   end

   // Lane 7 is finished on the same edge that publishes the whole vector.
   always_comb begin
      w_y_next = '0;
      for (int i = 0; i < 8; i++) w_y_next[i*OW +: OW] = r_y[i];
      w_y_next[7*OW +: OW] = w_sat;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         done2   <= 1'b0;
         busy    <= 1'b0;
         y_out   <= '0;
         r_acc   <= '0;
         r_k     <= '0;
         r_n     <= '0;
`ifdef DCT_IDCT_EN
         r_inv   <= 1'b0;
`endif
         for (int i = 0; i < 8; i++) begin
            r_x[i] <= '0;
            r_y[i] <= '0;
         end
      end else begin
         case (r_state)
            IDLE: begin
               if (start2) begin
                  for (int i = 0; i < 8; i++) r_x[i] <= x_in[i*DW +: DW];
`ifdef DCT_IDCT_EN
                  r_inv   <= inv;
`endif
                  r_acc   <= '0;
                  r_k     <= '0;
                  r_n     <= '0;
                  busy    <= 1'b1;
                  r_state <= MAC;
               end
            end
            MAC: begin
               r_n <= r_n + 3'd1;
               if (r_n == 3'd7) begin
                  r_y[r_k] <= w_sat;
                  r_acc    <= '0;
                  r_k      <= r_k + 3'd1;
                  if (r_k == 3'd7) begin
                     y_out   <= w_y_next;
                     done2   <= 1'b1;
                     busy    <= 1'b0;
                     r_state <= DONE;
                  end
               end else begin
                  r_acc <= w_sum;
               end
            end
            DONE: begin
               if (!start2) begin
                  done2   <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dct8_1d_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dct8_1d_engine : randomized self-checking bench with a real-valued    |
// | DCT reference table. Rev 1.0                                              |
// +--------------------------------------------------------------------------+
module tb_dct8_1d_engine;

   logic         clk = 1'b0;
   logic         rst;
   logic         start2;
   logic         inv;
   logic [127:0] x_in;
   logic         done2;
   logic         busy;
   logic [127:0] y_out;

   int n_tests = 0;
   int n_fail  = 0;
   int c_tab [8][8];

   always #5 clk = ~clk;

   dct8_1d_engine #(.DW(16), .CW(12), .OW(16)) dut (
      .clk    (clk),
      .rst    (rst),
      .start2 (start2),
`ifdef DCT_IDCT_EN
      .inv    (inv),
`endif
      .x_in   (x_in),
      .done2  (done2),
      .busy   (busy),
      .y_out  (y_out)
   );

   function automatic real basis(input int k, input int n);
      real c;
      c = (k == 0) ? $sqrt(1.0/8.0) : 0.5;
      return c * $cos(real'((2*n+1)*k) * 3.14159265358979 / 16.0);
   endfunction

   task automatic build_table();
      real v;
      for (int k = 0; k < 8; k++)
         for (int n = 0; n < 8; n++) begin
            v = basis(k, n) * 2048.0;
            c_tab[k][n] = (v >= 0.0) ? $rtoi(v + 0.5) : $rtoi(v - 0.5);
         end
   endtask

   // Integer reference: exact dot product, round half up, clamp to 16 bits.
   task automatic model(input int x[8], input bit inv_m, output int y[8]);
      longint s;
      for (int k = 0; k < 8; k++) begin
         s = 0;
         for (int n = 0; n < 8; n++)
            s += longint'(x[n]) * longint'(inv_m ? c_tab[n][k] : c_tab[k][n]);
         s = (s + 1024) >>> 11;
         if (s > 32767) s = 32767;
         if (s < -32768) s = -32768;
         y[k] = int'(s);
      end
   endtask

   function automatic int lane(input int k);
      logic signed [15:0] v;
      v = y_out[k*16 +: 16];
      return int'(v);
   endfunction

   task automatic drive_x(input int x[8]);
      for (int n = 0; n < 8; n++) x_in[n*16 +: 16] = 16'(x[n]);
   endtask

   task automatic rand_vec(output int x[8]);
      logic [15:0] r16;
      for (int n = 0; n < 8; n++) begin
         r16  = 16'($urandom);
         x[n] = int'($signed(r16));
      end
   endtask

   // Accept a vector and wait (bounded) for done2; start2 is left high.
   task automatic run_tx(input int x[8], input bit inv_v, output int lat);
      drive_x(x);
      inv    = inv_v;
      start2 = 1'b1;
      @(posedge clk); #1;
      lat = -1;
      for (int c = 1; c <= 200; c++) begin
         @(posedge clk); #1;
         if (done2) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start2 = 1'b0; inv = 1'b0; x_in = '0;
      repeat (2) @(posedge clk);
      #1;
      n_tests++; if (done2 !== 1'b0) begin n_fail++; $display("FAIL reset_done2 got %b expected 0", done2); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b expected 0", busy); end
      n_tests++; if (y_out !== 128'd0) begin n_fail++; $display("FAIL reset_y got %h expected 0", y_out); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic check_lanes(input string tag, input int exp[8]);
      for (int k = 0; k < 8; k++) begin
         n_tests++;
         if (lane(k) !== exp[k]) begin
            n_fail++;
            $display("FAIL %s lane %0d got %0d expected %0d", tag, k, lane(k), exp[k]);
         end
      end
   endtask

   task automatic test_dc();
      int x[8]; int y[8]; int lat;
      for (int n = 0; n < 8; n++) x[n] = 100;
      model(x, 1'b0, y);
      run_tx(x, 1'b0, lat);
      n_tests++; if (lat != 64) begin n_fail++; $display("FAIL dc_latency got %0d expected 64", lat); end
      n_tests++; if (lane(0) !== 283) begin n_fail++; $display("FAIL dc_y0 got %0d expected 283", lane(0)); end
      check_lanes("dc", y);
      start2 = 1'b0;
      @(posedge clk); #1;
      n_tests++; if (done2 !== 1'b0) begin n_fail++; $display("FAIL dc_release got %b expected 0", done2); end
   endtask

   task automatic test_impulse();
      int x[8]; int y[8]; int lat; real ref_v;
      for (int n = 0; n < 8; n++) x[n] = 0;
      x[0] = 1000;
      model(x, 1'b0, y);
      run_tx(x, 1'b0, lat);
      n_tests++; if (lane(0) !== 354) begin n_fail++; $display("FAIL imp_y0 got %0d expected 354", lane(0)); end
      n_tests++; if (lane(1) !== 490) begin n_fail++; $display("FAIL imp_y1 got %0d expected 490", lane(1)); end
      check_lanes("impulse", y);
      for (int k = 0; k < 8; k++) begin
         ref_v = 1000.0 * basis(k, 0);
         n_tests++;
         if ((real'(lane(k)) - ref_v > 1.0) || (ref_v - real'(lane(k)) > 1.0)) begin
            n_fail++;
            $display("FAIL imp_float lane %0d got %0d expected %f +-1", k, lane(k), ref_v);
         end
      end
      start2 = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_saturation();
      int x[8]; int lat;
      for (int pass = 0; pass < 2; pass++) begin
         for (int n = 0; n < 8; n++) x[n] = (pass == 0) ? 32767 : -32768;
         run_tx(x, 1'b0, lat);
         n_tests++;
         if (lane(0) !== ((pass == 0) ? 32767 : -32768)) begin
            n_fail++;
            $display("FAIL sat_y0 pass %0d got %0d expected %0d", pass, lane(0), (pass == 0) ? 32767 : -32768);
         end
         for (int k = 1; k < 8; k++) begin
            n_tests++;
            if (lane(k) !== 0) begin n_fail++; $display("FAIL sat_ac lane %0d got %0d expected 0", k, lane(k)); end
         end
         start2 = 1'b0;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_random();
      int x[8]; int y[8]; int lat;
      for (int t = 0; t < 8; t++) begin
         rand_vec(x);
         if (t >= 4) for (int n = 0; n < 8; n++) x[n] = x[n] >>> 6;
         model(x, 1'b0, y);
         run_tx(x, 1'b0, lat);
         n_tests++; if (lat != 64) begin n_fail++; $display("FAIL rnd_latency got %0d expected 64", lat); end
         check_lanes("random", y);
         start2 = 1'b0;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      int x[8]; int y[8]; int lat; int hold_err; logic [127:0] y_old;
      rand_vec(x);
      model(x, 1'b0, y);
      run_tx(x, 1'b0, lat);
      check_lanes("hs_first", y);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         n_tests++; if (done2 !== 1'b1) begin n_fail++; $display("FAIL hs_hold_done2 got %b expected 1", done2); end
         n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hs_hold_busy got %b expected 0", busy); end
      end
      y_old  = y_out;
      start2 = 1'b0;
      @(posedge clk); #1;
      n_tests++; if (done2 !== 1'b0) begin n_fail++; $display("FAIL hs_drop got %b expected 0", done2); end
      rand_vec(x);
      model(x, 1'b0, y);
      drive_x(x);
      start2 = 1'b1;
      @(posedge clk); #1;
      hold_err = 0; lat = -1;
      for (int c = 1; c <= 200; c++) begin
         if (c == 10) begin
            n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL hs_busy got %b expected 1", busy); end
         end
         @(posedge clk); #1;
         if (done2) begin lat = c; break; end
         if (y_out !== y_old) hold_err++;
      end
      n_tests++; if (hold_err != 0) begin n_fail++; $display("FAIL hs_y_held got %0d changes expected 0", hold_err); end
      n_tests++; if (lat != 64) begin n_fail++; $display("FAIL hs_latency got %0d expected 64", lat); end
      check_lanes("hs_second", y);
      start2 = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_early_release();
      int x[8]; int y[8]; int lat;
      rand_vec(x);
      model(x, 1'b0, y);
      drive_x(x);
      start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      x_in   = ~x_in;
      lat = -1;
      for (int c = 1; c <= 200; c++) begin
         @(posedge clk); #1;
         if (done2) begin lat = c; break; end
      end
      n_tests++; if (lat != 64) begin n_fail++; $display("FAIL early_latency got %0d expected 64", lat); end
      check_lanes("early", y);
      @(posedge clk); #1;
      n_tests++; if (done2 !== 1'b0) begin n_fail++; $display("FAIL early_pulse got %b expected 0", done2); end
      repeat (3) @(posedge clk);
      #1;
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL early_idle_busy got %b expected 0", busy); end
   endtask

   task automatic test_reset_mid();
      int x[8]; int y[8]; int lat;
      rand_vec(x);
      drive_x(x);
      start2 = 1'b1;
      @(posedge clk); #1;
      repeat (29) @(posedge clk);
      #1;
      rst = 1'b1; start2 = 1'b0;
      @(posedge clk); #1;
      n_tests++; if (done2 !== 1'b0) begin n_fail++; $display("FAIL rstmid_done2 got %b expected 0", done2); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b expected 0", busy); end
      n_tests++; if (y_out !== 128'd0) begin n_fail++; $display("FAIL rstmid_y got %h expected 0", y_out); end
      rst = 1'b0;
      @(posedge clk); #1;
      for (int n = 0; n < 8; n++) x[n] = 100;
      model(x, 1'b0, y);
      run_tx(x, 1'b0, lat);
      n_tests++; if (lat != 64) begin n_fail++; $display("FAIL rstmid_latency got %0d expected 64", lat); end
      n_tests++; if (lane(0) !== 283) begin n_fail++; $display("FAIL rstmid_y0 got %0d expected 283", lane(0)); end
      check_lanes("rstmid", y);
      start2 = 1'b0;
      @(posedge clk); #1;
   endtask

`ifdef DCT_IDCT_EN
   task automatic test_inverse();
      int x[8]; int y[8]; int lat;
      for (int n = 0; n < 8; n++) x[n] = 0;
      x[0] = 283;
      run_tx(x, 1'b1, lat);
      for (int k = 0; k < 8; k++) begin
         n_tests++;
         if (lane(k) < 99 || lane(k) > 101) begin
            n_fail++;
            $display("FAIL inv_dc lane %0d got %0d expected 100+-1", k, lane(k));
         end
      end
      start2 = 1'b0;
      @(posedge clk); #1;
      rand_vec(x);
      model(x, 1'b1, y);
      run_tx(x, 1'b1, lat);
      n_tests++; if (lat != 64) begin n_fail++; $display("FAIL inv_latency got %0d expected 64", lat); end
      check_lanes("inv_rand", y);
      start2 = 1'b0; inv = 1'b0;
      @(posedge clk); #1;
   endtask
`endif

   initial begin
      build_table();
      test_reset();
      test_dc();
      test_impulse();
      test_saturation();
      test_random();
      test_back_to_back();
      test_early_release();
      test_reset_mid();
`ifdef DCT_IDCT_EN
      test_inverse();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
